// File: rtl/lockstep_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lockstep_pkg
//  Description : Shared constants and types for the lockstep control-register
//                bus master: default register address, FSM state encoding,
//                write-enable polarity and byte-enable pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
package lockstep_pkg;

   // Address of the lockstep control register on the system bus
   localparam logic [31:0] LOCKSTEP_ADDRESS = 32'h1020_4400;

   // Bus write-enable is active-low: 0 selects a write, 1 selects a read
   localparam logic WEN_WRITE = 1'b0;
   localparam logic WEN_READ  = 1'b1;

   // The control register is always accessed as a full word
   localparam logic [3:0] BE_FULL_WORD = 4'hF;

   // Width of the request-to-response watchdog counter
   localparam int unsigned TCNT_WIDTH = 8;

   // Master FSM states
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REQ      = 2'd1,
      ST_WAIT_RSP = 2'd2,
      ST_DONE     = 2'd3
   } lockstep_state_e;

endpackage : lockstep_pkg
`default_nettype wire

// File: rtl/lockstep_ctrl_master.sv
`default_nettype none
// ============================================================================
//  Module      : lockstep_ctrl_master
//  Description : Single-outstanding bus master that turns local read/write
//                commands into one request/grant/response transaction on the
//                lockstep control register, with response-ID matching and a
//                watchdog that completes the command with an error if no
//                response arrives in time.
//  Revision    : 1.0 - initial release
// ============================================================================
module lockstep_ctrl_master
   import lockstep_pkg::*;
#(
   parameter int unsigned ID_WIDTH    = 5,
   parameter logic [31:0] TARGET_ADDR = LOCKSTEP_ADDRESS,
   parameter int unsigned TIMEOUT     = 16    // legal range 2..255
) (
   input  logic                clk_i,
   input  logic                rst_ni,

   // Local command / completion interface
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic                cmd_write_i,
   input  logic [31:0]         cmd_wdata_i,
   output logic                rsp_valid_o,
   output logic [31:0]         rsp_rdata_o,
   output logic                rsp_error_o,
   output logic                busy_o,

   // System bus request / response interface
   output logic                req_o,
   output logic [31:0]         addr_o,
   output logic                wen_o,
   output logic [31:0]         wdata_o,
   output logic [3:0]          be_o,
   output logic [ID_WIDTH-1:0] id_o,
   input  logic                gnt_i,
   input  logic                r_valid_i,
   input  logic                r_opc_i,
   input  logic [ID_WIDTH-1:0] r_id_i,
   input  logic [31:0]         r_rdata_i
);

   // Counter value seen in the last cycle the master is allowed to wait;
   // the request phase plus response wait therefore lasts TIMEOUT cycles.
   localparam logic [TCNT_WIDTH-1:0] c_TCNT_LIMIT = TCNT_WIDTH'(TIMEOUT - 1);

   lockstep_state_e       r_state;
   lockstep_state_e       w_state_nxt;

   logic                  r_req;
   logic [31:0]           r_addr;
   logic                  r_wen;
   logic [31:0]           r_wdata;
   logic [3:0]            r_be;
   logic [ID_WIDTH-1:0]   r_id;
   logic [TCNT_WIDTH-1:0] r_tcnt;
   logic [31:0]           r_rsp_rdata;
   logic                  r_rsp_error;

   logic                  w_accept;
   logic                  w_active;
   logic                  w_rsp_match;
   logic                  w_timeout;

   // Handshake and qualification terms shared by the FSM and datapath
   always_comb begin
      w_accept    = (r_state == ST_IDLE) & cmd_valid_i;
      w_active    = (r_state == ST_REQ) | (r_state == ST_WAIT_RSP);
      // Responses only count while waiting; anything seen in IDLE/REQ is stray
      w_rsp_match = (r_state == ST_WAIT_RSP) & r_valid_i & (r_id_i == r_id);
      w_timeout   = w_active & (r_tcnt == c_TCNT_LIMIT);
   end

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state logic; a matching response beats a same-cycle timeout
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            if (w_timeout) begin
               w_state_nxt = ST_DONE;
            end else if (gnt_i) begin
               w_state_nxt = ST_WAIT_RSP;
            end
         end
         ST_WAIT_RSP: begin
            if (w_rsp_match || w_timeout) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // FSM-decoded outputs
   always_comb begin
      cmd_ready_o = (r_state == ST_IDLE);
      busy_o      = (r_state != ST_IDLE);
      rsp_valid_o = (r_state == ST_DONE);
   end

   // Bus request fields: loaded on command accept, held until grant/timeout
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_req   <= 1'b0;
         r_addr  <= '0;
         r_wen   <= 1'b0;
         r_wdata <= '0;
         r_be    <= '0;
      end else if (w_accept) begin
         r_req   <= 1'b1;
         r_addr  <= TARGET_ADDR;
         r_wen   <= cmd_write_i ? WEN_WRITE : WEN_READ;
         r_wdata <= cmd_write_i ? cmd_wdata_i : 32'h0;
         r_be    <= BE_FULL_WORD;
      end else if ((r_state == ST_REQ) && (gnt_i || w_timeout)) begin
         r_req   <= 1'b0;
      end
   end

   // Watchdog: cleared when a request is launched, counts while in flight
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_tcnt <= '0;
      end else if (w_accept) begin
         r_tcnt <= '0;
      end else if (w_active) begin
         r_tcnt <= r_tcnt + TCNT_WIDTH'(1);
      end
   end

   // Completion data, held until the next completion overwrites it
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rsp_rdata <= '0;
         r_rsp_error <= 1'b0;
      end else if (w_rsp_match) begin
         r_rsp_rdata <= (r_wen == WEN_READ) ? r_rdata_i : 32'h0;
         r_rsp_error <= r_opc_i;
      end else if (w_timeout) begin
         r_rsp_rdata <= 32'h0;
         r_rsp_error <= 1'b1;
      end
   end

   // Transaction ID advances once per completion, timed-out ones included
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_id <= '0;
      end else if (r_state == ST_DONE) begin
         r_id <= r_id + ID_WIDTH'(1);
      end
   end

   assign req_o       = r_req;
   assign addr_o      = r_addr;
   assign wen_o       = r_wen;
   assign wdata_o     = r_wdata;
   assign be_o        = r_be;
   assign id_o        = r_id;
   assign rsp_rdata_o = r_rsp_rdata;
   assign rsp_error_o = r_rsp_error;

endmodule : lockstep_ctrl_master
`default_nettype wire

// File: tb/tb_lockstep_ctrl_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lockstep_ctrl_master
//  Description : Directed, table-driven bench for lockstep_ctrl_master plus
//                hand-written sequences for timeout, reset and ID wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lockstep_ctrl_master;

   localparam int IDW = 5;

   logic           clk_i = 1'b0;
   logic           rst_ni = 1'b0;
   logic           cmd_valid_i = 1'b0;
   logic           cmd_ready_o;
   logic           cmd_write_i = 1'b0;
   logic [31:0]    cmd_wdata_i = '0;
   logic           rsp_valid_o;
   logic [31:0]    rsp_rdata_o;
   logic           rsp_error_o;
   logic           busy_o;
   logic           req_o;
   logic [31:0]    addr_o;
   logic           wen_o;
   logic [31:0]    wdata_o;
   logic [3:0]     be_o;
   logic [IDW-1:0] id_o;
   logic           gnt_i = 1'b0;
   logic           r_valid_i = 1'b0;
   logic           r_opc_i = 1'b0;
   logic [IDW-1:0] r_id_i = '0;
   logic [31:0]    r_rdata_i = '0;

   int             checks = 0;
   int             failures = 0;
   logic [IDW-1:0] exp_id = '0;

   lockstep_ctrl_master #(
      .ID_WIDTH    (IDW),
      .TARGET_ADDR (32'h1020_4400),
      .TIMEOUT     (16)
   ) u_dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_write_i (cmd_write_i),
      .cmd_wdata_i (cmd_wdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_error_o (rsp_error_o),
      .busy_o      (busy_o),
      .req_o       (req_o),
      .addr_o      (addr_o),
      .wen_o       (wen_o),
      .wdata_o     (wdata_o),
      .be_o        (be_o),
      .id_o        (id_o),
      .gnt_i       (gnt_i),
      .r_valid_i   (r_valid_i),
      .r_opc_i     (r_opc_i),
      .r_id_i      (r_id_i),
      .r_rdata_i   (r_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        write;
      logic [31:0] wdata;
      int          gnt_dly;     // REQ cycles without grant
      int          rsp_dly;     // WAIT_RSP cycles before first r_valid_i
      logic        wrong_id;    // send a mismatching-ID response first
      logic        stray_req;   // pulse a matching r_valid_i during REQ
      logic        no_rsp;      // never respond (timeout)
      logic        opc;
      logic [31:0] bus_rdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_cyc;     // cycle of rsp_valid_o, accept edge = 0
   } txn_t;

   function automatic txn_t mk(logic w, logic [31:0] wd, int g, int r,
                               logic wr, logic st, logic nr, logic opc,
                               logic [31:0] brd, logic [31:0] erd,
                               logic eerr, int ecyc);
      txn_t t;
      t.write = w;      t.wdata = wd;      t.gnt_dly = g;    t.rsp_dly = r;
      t.wrong_id = wr;  t.stray_req = st;  t.no_rsp = nr;    t.opc = opc;
      t.bus_rdata = brd; t.exp_rdata = erd; t.exp_err = eerr; t.exp_cyc = ecyc;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Entered at a negedge with the DUT idle; leaves at the negedge where the
   // DUT is idle again so a following call is accepted back-to-back.
   task automatic run_txn(input txn_t t);
      int             cyc;
      bit             seen;
      logic [IDW-1:0] bad_id;
      bad_id = (exp_id == 5'd7) ? 5'd8 : 5'd7;
      chk("cmd_ready_idle", cmd_ready_o, 1);
      cmd_valid_i = 1'b1;
      cmd_write_i = t.write;
      cmd_wdata_i = t.wdata;
      @(negedge clk_i);
      cyc = 1;
      cmd_valid_i = 1'b0;
      cmd_wdata_i = 32'h0;
      for (int k = 0; k <= t.gnt_dly; k++) begin
         chk("req_high",  req_o, 1);
         chk("addr",      addr_o, 32'h1020_4400);
         chk("wen",       wen_o, t.write ? 0 : 1);
         chk("wdata",     wdata_o, t.write ? t.wdata : 32'h0);
         chk("be",        be_o, 4'hF);
         chk("id",        id_o, exp_id);
         chk("busy_req",  busy_o, 1);
         chk("ready_req", cmd_ready_o, 0);
         gnt_i = (k == t.gnt_dly);
         if (t.stray_req) begin
            r_valid_i = 1'b1;
            r_id_i    = exp_id;
            r_rdata_i = 32'hBAD0_0000;
         end
         @(negedge clk_i);
         cyc++;
         r_valid_i = 1'b0;
      end
      gnt_i = 1'b0;
      chk("req_drop", req_o, 0);
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         if (!t.no_rsp) begin
            if (t.wrong_id && k == t.rsp_dly) begin
               r_valid_i = 1'b1; r_id_i = bad_id;
               r_rdata_i = 32'h0BAD_0BAD; r_opc_i = 1'b1;
            end else if (k == t.rsp_dly + (t.wrong_id ? 1 : 0)) begin
               r_valid_i = 1'b1; r_id_i = exp_id;
               r_rdata_i = t.bus_rdata; r_opc_i = t.opc;
            end
         end
         @(negedge clk_i);
         cyc++;
         r_valid_i = 1'b0;
         r_opc_i   = 1'b0;
         if (rsp_valid_o) seen = 1'b1;
      end
      chk("rsp_seen",  seen, 1);
      chk("done_cyc",  cyc, t.exp_cyc);
      chk("rsp_rdata", rsp_rdata_o, t.exp_rdata);
      chk("rsp_error", rsp_error_o, t.exp_err);
      chk("busy_done", busy_o, 1);
      @(negedge clk_i);
      chk("rsp_one_pulse", rsp_valid_o, 0);
      chk("rsp_hold",      rsp_rdata_o, t.exp_rdata);
      chk("ready_after",   cmd_ready_o, 1);
      exp_id = exp_id + 1'b1;
   endtask

   txn_t tbl[9];

   initial begin
      int  cyc;
      bit  seen;

      tbl[0] = mk(1, 32'h0000_0001, 0, 0,  0, 0, 0, 0, 32'h5A5A_5A5A, 32'h0,          0, 3);
      tbl[1] = mk(0, 32'h1234_5678, 3, 0,  0, 0, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 6);
      tbl[2] = mk(0, 32'h0,         0, 0,  1, 0, 0, 0, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 4);
      tbl[3] = mk(0, 32'h0,         0, 1,  0, 1, 0, 0, 32'h0102_0304, 32'h0102_0304, 0, 4);
      tbl[4] = mk(0, 32'h0,         1, 2,  0, 0, 0, 1, 32'hAAAA_5555, 32'hAAAA_5555, 1, 6);
      tbl[5] = mk(1, 32'hFFFF_0000, 0, 2,  0, 0, 0, 0, 32'hFFFF_FFFF, 32'h0,          0, 5);
      tbl[6] = mk(0, 32'h0,         0, 14, 0, 0, 0, 0, 32'h600D_F00D, 32'h600D_F00D, 0, 17);
      tbl[7] = mk(0, 32'h0,         0, 0,  0, 0, 1, 0, 32'h0,         32'h0,          1, 17);
      tbl[8] = mk(1, 32'h00C0_FFEE, 2, 0,  0, 0, 0, 0, 32'h1111_1111, 32'h0,          0, 5);

      // Reset state
      #3;
      chk("rst_req",   req_o, 0);
      chk("rst_busy",  busy_o, 0);
      chk("rst_rspv",  rsp_valid_o, 0);
      chk("rst_ready", cmd_ready_o, 1);
      chk("rst_addr",  addr_o, 0);
      chk("rst_be",    be_o, 0);
      chk("rst_id",    id_o, 0);
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Stray responses in IDLE are ignored
      r_valid_i = 1'b1; r_id_i = '0; r_rdata_i = 32'h7777_7777;
      repeat (2) begin
         @(negedge clk_i);
         chk("idle_stray_rspv", rsp_valid_o, 0);
         chk("idle_stray_busy", busy_o, 0);
      end
      r_valid_i = 1'b0;

      for (int i = 0; i < 9; i++) run_txn(tbl[i]);

      // Timeout while still in REQ (grant never arrives)
      cmd_valid_i = 1'b1; cmd_write_i = 1'b0;
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      cyc = 1; seen = 1'b0;
      chk("nogn_req", req_o, 1);
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk_i);
         cyc++;
         if (rsp_valid_o) seen = 1'b1;
      end
      chk("nogn_seen",  seen, 1);
      chk("nogn_cyc",   cyc, 17);
      chk("nogn_err",   rsp_error_o, 1);
      chk("nogn_rdata", rsp_rdata_o, 0);
      chk("nogn_req_o", req_o, 0);
      @(negedge clk_i);
      exp_id = exp_id + 1'b1;
      chk("nogn_ready", cmd_ready_o, 1);
      chk("nogn_id",    id_o, exp_id);

      // Asynchronous reset while waiting for a response
      cmd_valid_i = 1'b1; cmd_write_i = 1'b0;
      @(negedge clk_i);
      cmd_valid_i = 1'b0; gnt_i = 1'b1;
      @(negedge clk_i);
      gnt_i = 1'b0;
      chk("prerst_busy", busy_o, 1);
      #2 rst_ni = 1'b0;
      #1;
      chk("arst_req",   req_o, 0);
      chk("arst_busy",  busy_o, 0);
      chk("arst_rspv",  rsp_valid_o, 0);
      chk("arst_id",    id_o, 0);
      chk("arst_wen",   wen_o, 0);
      chk("arst_err",   rsp_error_o, 0);
      chk("arst_wdata", wdata_o, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      r_valid_i = 1'b1; r_rdata_i = 32'hFEED_FACE;
      for (int k = 0; k < 3; k++) begin
         r_id_i = (k == 0) ? exp_id : '0;
         @(negedge clk_i);
         chk("post_rst_rspv", rsp_valid_o, 0);
      end
      r_valid_i = 1'b0;
      exp_id = '0;
      run_txn(mk(0, 32'h0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 1, 17));
      run_txn(mk(1, 32'h0000_00A5, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 3));

      // 32 back-to-back commands, ID wraps through 31 -> 0
      for (int i = 0; i < 32; i++) begin
         run_txn(mk(i[0], 32'h100 + i, 0, 0, 0, 0, 0, 0, 32'hC000_0000 + i,
                    i[0] ? 32'h0 : 32'hC000_0000 + i, 0, 3));
      end
      chk("wrap_id", id_o, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog so the bench always ends on its own
   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "bench watchdog expired");
   end

endmodule : tb_lockstep_ctrl_master
`default_nettype wire

// File: doc/lockstep_ctrl_master.md
LOCKSTEP_CTRL_MASTER -- requirements
Module: lockstep_ctrl_master

Interface
REQ-001 Parameter ID_WIDTH, 5, transaction ID width SHALL be configurable.
REQ-002 Parameter TARGET_ADDR, 32'h10204400, SHALL be the lockstep control register address driven on addr_o.
REQ-003 Parameter TIMEOUT, 16, SHALL be the max cycles from request issue to response before error (range 2..255).
REQ-004 One clock; reset is asynchronous and active-low: clk_i  input  1  rising-edge clock.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 cmd_valid_i  input  1  local command valid.
REQ-007 cmd_ready_o  output  1  command accepted when high with cmd_valid_i.
REQ-008 cmd_write_i  input  1  1 = write control register, 0 = read.
REQ-009 cmd_wdata_i  input  32  write data.
REQ-010 rsp_valid_o  output  1  one-cycle completion pulse, no backpressure.
REQ-011 rsp_rdata_o  output  32  read data (0 for writes).
REQ-012 rsp_error_o  output  1  completion was timeout or r_opc_i=1.
REQ-013 busy_o  output  1  transaction in flight.
REQ-014 Bus side SHALL be: req_o out 1; addr_o out 32; wen_o out 1 (0 = write, 1 = read); wdata_o out 32; be_o out 4; id_o out ID_WIDTH; gnt_i in 1; r_valid_i in 1; r_opc_i in 1; r_id_i in ID_WIDTH; r_rdata_i in 32.

Function
REQ-015 FSM SHALL have states IDLE, REQ, WAIT_RSP, DONE; cmd_ready_o = 1 only in IDLE.
REQ-016 IDLE: on cmd_valid_i & cmd_ready_o, SHALL register wen_o = ~cmd_write_i, wdata_o = cmd_wdata_i (0 for reads) and go to REQ.
REQ-017 REQ: req_o = 1, addr_o = TARGET_ADDR, be_o = 4'hF; all bus outputs SHALL be registered and stable until gnt_i.
REQ-018 REQ with gnt_i = 1 SHALL transition to WAIT_RSP and drop req_o the next cycle; minimum request phase 1 cycle.
REQ-019 r_valid_i while in REQ or IDLE SHALL be ignored.
REQ-020 WAIT_RSP: r_valid_i & (r_id_i == id_o) SHALL capture r_rdata_i (reads only), rsp_error_o = r_opc_i, go to DONE.
REQ-021 r_valid_i with mismatching r_id_i SHALL be ignored without state change.
REQ-022 DONE: rsp_valid_o = 1 for exactly one cycle, then IDLE; rsp_rdata_o/rsp_error_o held until the next completion.
REQ-023 8-bit timeout counter SHALL clear on entry to REQ, increment each cycle in REQ/WAIT_RSP; reaching TIMEOUT SHALL force DONE with rsp_error_o = 1, rsp_rdata_o = 0, req_o = 0.
REQ-024 Timeout and matching r_valid_i in same cycle: response SHALL win (no error unless r_opc_i).
REQ-025 id_o SHALL increment modulo 2^ID_WIDTH on every DONE exit, including timeouts.
REQ-026 Minimum command-to-response latency: accept at cycle 0, req_o at 1, r_valid_i at 2, rsp_valid_o at 3; back-to-back acceptance at cycle 4.
REQ-027 busy_o SHALL be 1 in REQ, WAIT_RSP, DONE.

Reset
REQ-028 Reset SHALL act immediately, mid-transaction included: state IDLE, req_o, wen_o, rsp_valid_o, rsp_error_o, busy_o = 0; addr_o, wdata_o, be_o, rsp_rdata_o = 0; id_o and timeout counter = 0.
REQ-029 Abandoned transactions SHALL produce no rsp_valid_o after reset release; first post-reset request uses id 0.

Structure
REQ-030 Shared package lockstep_pkg SHALL hold LOCKSTEP_ADDRESS, the FSM state enum, and wen encoding constants.
REQ-031 No sub-module; single module with one FSM and one counter.

Verification
REQ-032 Write 32'h0000_0001, gnt_i = 1 same cycle, r_valid_i next cycle id 0 -> req_o one cycle, wen_o = 0, addr_o = 32'h10204400, rsp_valid_o at cycle 3, rsp_error_o = 0.
REQ-033 Read, gnt_i delayed 3 cycles, r_rdata_i = 32'hDEAD_BEEF -> req_o/bus fields stable 4 cycles, rsp_rdata_o = 32'hDEAD_BEEF.
REQ-034 Read, r_valid_i with r_id_i = 5'd7 (wrong), then correct id -> wrong one ignored, single rsp_valid_o.
REQ-035 Read, no r_valid_i -> rsp_valid_o with rsp_error_o = 1 after TIMEOUT = 16 cycles; next command uses id 1.
REQ-036 Assert rst_ni low during WAIT_RSP -> req_o, busy_o = 0 asynchronously; no rsp_valid_o afterwards.
REQ-037 32 back-to-back commands -> id_o wraps 31 to 0, no command lost.
